// File: rtl/unidade_busca_pkg.sv
// unidade_busca_pkg: shared types for the fetch/branch unit.
package unidade_busca_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } branch_op_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/unidade_busca_if.sv
// unidade_busca_if: control, branch and instruction-memory signals of the fetch unit.
// TrapMisaligned exists only when UNIDADE_BUSCA_MISALIGN_TRAP_EN is defined.
interface unidade_busca_if #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
);
    logic            Fetch;
    logic            PCWrite;
    logic            PCWriteCond;
    logic [2:0]      BranchOp;
    logic [XLEN-1:0] OpA;
    logic [XLEN-1:0] OpB;
    logic [XLEN-1:0] Target;
    logic [XLEN-1:0] IMemAddr;
    logic            IMemReq;
    logic            IMemAck;
    logic [ILEN-1:0] IMemData;
    logic [ILEN-1:0] Instr;
    logic [XLEN-1:0] InstrPC;
    logic            InstrValid;
    logic            Busy;
    logic            BranchTaken;
`ifdef UNIDADE_BUSCA_MISALIGN_TRAP_EN
    logic            TrapMisaligned;
`endif

    modport slave (
        input  Fetch, PCWrite, PCWriteCond, BranchOp, OpA, OpB, Target, IMemAck, IMemData,
`ifdef UNIDADE_BUSCA_MISALIGN_TRAP_EN
        output TrapMisaligned,
`endif
        output IMemAddr, IMemReq, Instr, InstrPC, InstrValid, Busy, BranchTaken
    );

    modport master (
        output Fetch, PCWrite, PCWriteCond, BranchOp, OpA, OpB, Target, IMemAck, IMemData,
`ifdef UNIDADE_BUSCA_MISALIGN_TRAP_EN
        input  TrapMisaligned,
`endif
        input  IMemAddr, IMemReq, Instr, InstrPC, InstrValid, Busy, BranchTaken
    );
endinterface

// File: rtl/unidade_busca_comparador_desvio.sv
// comparador_desvio: RV64 branch condition evaluator (funct3 encoding).
module comparador_desvio
    import unidade_busca_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] OpA,
    input  logic [XLEN-1:0] OpB,
    input  logic [2:0]      BranchOp,
    output logic            Cond
);
    logic w_eq;
    logic w_lt;
    logic w_ltu;

    always_comb begin
        w_eq  = OpA == OpB;
        w_lt  = $signed(OpA) < $signed(OpB);
        w_ltu = OpA < OpB;
        Cond  = (BranchOp == BEQ)  ?  w_eq  :
                (BranchOp == BNE)  ? !w_eq  :
                (BranchOp == BLT)  ?  w_lt  :
                (BranchOp == BGE)  ? !w_lt  :
                (BranchOp == BLTU) ?  w_ltu :
                (BranchOp == BGEU) ? !w_ltu : 1'b0;
    end
endmodule

// File: rtl/unidade_busca.sv
// unidade_busca: PC register, instruction fetch handshake, IR and branch redirect.
// Define UNIDADE_BUSCA_MISALIGN_TRAP_EN to trap redirects to non-word-aligned targets.
module unidade_busca
    import unidade_busca_pkg::*;
#(
    parameter int              XLEN         = 64,
    parameter int              ILEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              PC_STEP      = 4
) (
    input  logic          Clk,
    input  logic          Reset_n,
    unidade_busca_if.slave bus
);
    fetch_state_t    r_state;
    fetch_state_t    w_next;
    logic [XLEN-1:0] r_pc;
    logic [ILEN-1:0] r_instr;
    logic [XLEN-1:0] r_instr_pc;
    logic            r_valid;
    logic            r_taken;
    logic            w_cond;
    logic            w_busy;
    logic            w_want;
    logic            w_redir;
    logic            w_mis;
    logic            w_apply;
    logic            w_ack;

    comparador_desvio #(.XLEN(XLEN)) u_cmp (
        .OpA      (bus.OpA),
        .OpB      (bus.OpB),
        .BranchOp (bus.BranchOp),
        .Cond     (w_cond)
    );

    always_comb begin
        w_busy  = r_state == REQ;
        w_ack   = w_busy && bus.IMemAck;
        w_want  = bus.PCWrite || (bus.PCWriteCond && w_cond);
        w_redir = !w_busy && w_want;
`ifdef UNIDADE_BUSCA_MISALIGN_TRAP_EN
        w_mis   = bus.Target[1:0] != 2'b00;
`else
        w_mis   = 1'b0;
`endif
        w_apply = w_redir && !w_mis;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_busy)
            w_next = bus.IMemAck ? HOLD : REQ;
        else if (bus.Fetch)
            w_next = REQ;
    end

    always_comb begin
        bus.Busy        = w_busy;
        bus.IMemReq     = w_busy;
        bus.IMemAddr    = r_pc;
        bus.Instr       = r_instr;
        bus.InstrPC     = r_instr_pc;
        bus.InstrValid  = r_valid;
        bus.BranchTaken = r_taken;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pc       <= RESET_VECTOR;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
            r_taken    <= 1'b0;
        end else begin
            r_taken <= w_apply;
            if (w_ack) begin
                r_instr    <= bus.IMemData;
                r_instr_pc <= r_pc;
                r_pc       <= r_pc + XLEN'(PC_STEP);
                r_valid    <= 1'b1;
            end else if (w_apply) begin
                r_pc    <= bus.Target;
                r_valid <= 1'b0;
            end
        end
    end

`ifdef UNIDADE_BUSCA_MISALIGN_TRAP_EN
    logic r_trap;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            r_trap <= 1'b0;
        else
            r_trap <= w_redir && w_mis;
    end

    assign bus.TrapMisaligned = r_trap;
`endif

    // A redirect during an outstanding fetch is dropped; flag it so control bugs surface.
    a_redir_busy: assert property (@(posedge Clk) disable iff (!Reset_n) !(w_busy && w_want))
        else $warning("redirect ignored while fetch in flight");
endmodule

// File: tb/tb_unidade_busca.sv
// tb_unidade_busca: directed, table-driven self-checking bench for unidade_busca.
module tb_unidade_busca;
    import unidade_busca_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] tgt;
        logic        taken;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    logic [63:0] exp_pc;
    logic        exp_valid;
    vec_t        vecs [12];

    always #5 clk = ~clk;

    unidade_busca_if bus ();

    unidade_busca dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus.slave)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.Fetch       = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IMemAck     = 1'b0;
    endtask

    task automatic fetch_ack(input logic [31:0] data, input int waits);
        bus.Fetch = 1'b1;
        step();
        bus.Fetch = 1'b0;
        chk("req_busy", {62'd0, bus.IMemReq, bus.Busy}, 64'd3);
        for (int i = 0; i < waits; i++) begin
            step();
            chk("req_addr_stable", bus.IMemAddr, exp_pc);
        end
        bus.IMemAck  = 1'b1;
        bus.IMemData = data;
        step();
        bus.IMemAck = 1'b0;
        chk("ack_instr", {32'd0, bus.Instr}, {32'd0, data});
        chk("ack_instr_pc", bus.InstrPC, exp_pc);
        exp_pc    = exp_pc + 64'd4;
        exp_valid = 1'b1;
        chk("ack_pc", bus.IMemAddr, exp_pc);
        chk("ack_valid_idle", {62'd0, bus.InstrValid, bus.Busy}, 64'd2);
    endtask

    task automatic jump(input logic [63:0] tgt);
        bus.PCWrite = 1'b1;
        bus.Target  = tgt;
        step();
        bus.PCWrite = 1'b0;
        exp_pc    = tgt;
        exp_valid = 1'b0;
        chk("jump_pc", bus.IMemAddr, exp_pc);
        chk("jump_taken", {63'd0, bus.BranchTaken}, 64'd1);
    endtask

    initial begin
        vecs[0]  = '{3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h100, 1'b1};
        vecs[1]  = '{3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h180, 1'b0};
        vecs[2]  = '{3'b000, 64'd5, 64'd5, 64'h108, 1'b1};
        vecs[3]  = '{3'b001, 64'd5, 64'd5, 64'h1C0, 1'b0};
        vecs[4]  = '{3'b001, 64'd5, 64'd6, 64'h110, 1'b1};
        vecs[5]  = '{3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h1C4, 1'b0};
        vecs[6]  = '{3'b101, 64'd7, 64'd7, 64'h118, 1'b1};
        vecs[7]  = '{3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h120, 1'b1};
        vecs[8]  = '{3'b010, 64'd5, 64'd5, 64'h1C8, 1'b0};
        vecs[9]  = '{3'b011, 64'd0, 64'd1, 64'h1CC, 1'b0};
        vecs[10] = '{3'b100, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1D0, 1'b0};
        vecs[11] = '{3'b110, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h128, 1'b1};

        idle_inputs();
        bus.BranchOp = 3'b000;
        bus.OpA      = '0;
        bus.OpB      = '0;
        bus.Target   = '0;
        bus.IMemData = '0;
        exp_pc       = 64'd0;
        exp_valid    = 1'b0;

        // Reset state
        step();
        chk("rst_pc", bus.IMemAddr, 64'd0);
        chk("rst_instr", {32'd0, bus.Instr}, 64'd0);
        chk("rst_instr_pc", bus.InstrPC, 64'd0);
        chk("rst_flags", {60'd0, bus.InstrValid, bus.IMemReq, bus.Busy, bus.BranchTaken}, 64'd0);
        rst_n = 1'b1;
        step();

        // Fetch from reset, ack after three wait cycles
        fetch_ack(32'h00A0_0093, 3);

        // Branch comparator table, applied in HOLD/IDLE
        for (int i = 0; i < 12; i++) begin
            bus.PCWriteCond = 1'b1;
            bus.BranchOp    = vecs[i].op;
            bus.OpA         = vecs[i].a;
            bus.OpB         = vecs[i].b;
            bus.Target      = vecs[i].tgt;
            step();
            bus.PCWriteCond = 1'b0;
            if (vecs[i].taken) begin
                exp_pc    = vecs[i].tgt;
                exp_valid = 1'b0;
            end
            chk($sformatf("br%0d_taken", i), {63'd0, bus.BranchTaken}, {63'd0, vecs[i].taken});
            chk($sformatf("br%0d_pc", i), bus.IMemAddr, exp_pc);
            chk($sformatf("br%0d_valid", i), {63'd0, bus.InstrValid}, {63'd0, exp_valid});
            step();
            chk($sformatf("br%0d_pulse_end", i), {63'd0, bus.BranchTaken}, 64'd0);
        end

        // Unconditional redirect, then a redirect attempt while waiting for the ack
        jump(64'h300);
        bus.Fetch = 1'b1;
        step();
        bus.Fetch   = 1'b0;
        bus.PCWrite = 1'b1;
        bus.Target  = 64'h200;
        step();
        bus.PCWrite = 1'b0;
        chk("busy_redir_pc", bus.IMemAddr, 64'h300);
        chk("busy_redir_taken", {63'd0, bus.BranchTaken}, 64'd0);
        bus.IMemAck  = 1'b1;
        bus.IMemData = 32'h1111_2222;
        step();
        bus.IMemAck = 1'b0;
        chk("busy_redir_after_ack", bus.IMemAddr, 64'h304);
        chk("busy_redir_instr_pc", bus.InstrPC, 64'h300);
        exp_pc = 64'h304;

        // Ack outside REQ is ignored
        bus.IMemAck  = 1'b1;
        bus.IMemData = 32'hDEAD_BEEF;
        step();
        bus.IMemAck = 1'b0;
        chk("stray_ack_instr", {32'd0, bus.Instr}, 64'h1111_2222);
        chk("stray_ack_pc", bus.IMemAddr, 64'h304);

        // Redirect and fetch in the same cycle: fetch goes out from the target
        bus.PCWrite = 1'b1;
        bus.Fetch   = 1'b1;
        bus.Target  = 64'h400;
        step();
        idle_inputs();
        chk("rf_addr", bus.IMemAddr, 64'h400);
        chk("rf_req_taken", {62'd0, bus.IMemReq, bus.BranchTaken}, 64'd3);
        bus.IMemAck  = 1'b1;
        bus.IMemData = 32'h0000_0013;
        step();
        bus.IMemAck = 1'b0;
        chk("rf_ack_pc", bus.IMemAddr, 64'h404);
        chk("rf_ack_instr_pc", bus.InstrPC, 64'h400);
        exp_pc = 64'h404;

        // Asynchronous reset in the middle of a fetch
        bus.Fetch = 1'b1;
        step();
        bus.Fetch = 1'b0;
        chk("mid_req", {63'd0, bus.IMemReq}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {63'd0, bus.IMemReq}, 64'd0);
        chk("mid_rst_pc", bus.IMemAddr, 64'd0);
        chk("mid_rst_valid", {63'd0, bus.InstrValid}, 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = 64'd0;
        step();
        chk("post_rst_idle", {62'd0, bus.IMemReq, bus.Busy}, 64'd0);

        // PC wraps at the top of the address space
        jump(64'hFFFF_FFFF_FFFF_FFFC);
        step();
        fetch_ack(32'h0000_0073, 1);
        chk("wrap_pc", bus.IMemAddr, 64'd0);
        chk("wrap_instr_pc", bus.InstrPC, 64'hFFFF_FFFF_FFFF_FFFC);

        // Misaligned redirect target
        bus.PCWrite = 1'b1;
        bus.Target  = 64'h102;
        step();
        bus.PCWrite = 1'b0;
`ifdef UNIDADE_BUSCA_MISALIGN_TRAP_EN
        chk("mis_trap", {63'd0, bus.TrapMisaligned}, 64'd1);
        chk("mis_pc", bus.IMemAddr, 64'd0);
        chk("mis_taken", {63'd0, bus.BranchTaken}, 64'd0);
        chk("mis_valid", {63'd0, bus.InstrValid}, 64'd1);
        step();
        chk("mis_trap_end", {63'd0, bus.TrapMisaligned}, 64'd0);
`else
        chk("mis_pc", bus.IMemAddr, 64'h102);
        chk("mis_taken", {63'd0, bus.BranchTaken}, 64'd1);
        chk("mis_valid", {63'd0, bus.InstrValid}, 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
